// File: rtl/cam_pkg.sv
// Shared definitions for the parameterised CAM: update opcodes, update FSM
// states and the constant-function clog2 used to size address fields.
package cam_pkg;

   localparam logic OP_INSERT = 1'b0;
   localparam logic OP_DELETE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_COMMIT = 2'd2,
      ST_RESP   = 2'd3
   } upd_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/cam_match.sv
// Parallel key compare against every entry; an entry only matches when its
// valid bit is set.
module cam_match
   import cam_pkg::*;
#(
   parameter int KEY_W = 97,
   parameter int DEPTH = 16
) (
   input  logic [KEY_W-1:0]            key_i,
   input  logic [DEPTH-1:0][KEY_W-1:0] entries_i,
   input  logic [DEPTH-1:0]            valid_i,
   output logic [DEPTH-1:0]            match_o
);

   always_comb begin
      match_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match_o[i] = valid_i[i] && (entries_i[i] == key_i);
      end
   end

endmodule

// File: rtl/param_cam.sv
// Parameterised CAM: two-stage pipelined lookup port plus a four-state
// insert/delete update engine sharing the same compare logic.
module param_cam
   import cam_pkg::*;
#(
   parameter  int KEY_W  = 97,
   parameter  int VAL_W  = 14,
   parameter  int DEPTH  = 16,
   localparam int ADDR_W = clog2(DEPTH)
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              LookupReqValid,
   input  logic [KEY_W-1:0]  LookupReqKey,
   output logic              LookupRespValid,
   output logic              LookupRespHit,
   output logic [ADDR_W-1:0] LookupRespAddr,
   output logic [KEY_W-1:0]  LookupRespKey,
   output logic [VAL_W-1:0]  LookupRespValue,
   input  logic              UpdReqValid,
   output logic              UpdReqReady,
   input  logic              UpdReqOp,
   input  logic [KEY_W-1:0]  UpdReqKey,
   input  logic [VAL_W-1:0]  UpdReqValue,
   output logic              UpdRespValid,
   output logic              UpdRespSuccess,
   output logic [ADDR_W-1:0] UpdRespAddr,
   output logic              Full,
   output logic [ADDR_W:0]   EntryCount
);

   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

   function automatic logic [ADDR_W-1:0] lowest_idx(input logic [DEPTH-1:0] v);
      lowest_idx = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (v[i]) lowest_idx = ADDR_W'(i);
      end
   endfunction

   logic [DEPTH-1:0][KEY_W-1:0] key_q;
   logic [VAL_W-1:0]            val_q [DEPTH];
   logic [DEPTH-1:0]            valid_q;
   logic [ADDR_W:0]             cnt_q;

   // Lookup p0: compare against current contents, so a same-cycle commit is not seen
   logic [DEPTH-1:0]  lk_match_p0;
   logic              lk_hit_p0;
   logic [ADDR_W-1:0] lk_addr_p0;
   logic [VAL_W-1:0]  lk_val_p0;

   cam_match #(.KEY_W(KEY_W), .DEPTH(DEPTH)) u_lk_match (
      .key_i     (LookupReqKey),
      .entries_i (key_q),
      .valid_i   (valid_q),
      .match_o   (lk_match_p0)
   );

   always_comb begin
      lk_hit_p0  = |lk_match_p0;
      lk_addr_p0 = lowest_idx(lk_match_p0);
      lk_val_p0  = val_q[lk_addr_p0];
   end

   // Lookup p1: results zeroed on miss or idle
   logic              vld_p1_q;
   logic              hit_p1_q;
   logic [ADDR_W-1:0] addr_p1_q;
   logic [VAL_W-1:0]  val_p1_q;
   logic [KEY_W-1:0]  key_p1_q;
   logic              lk_take_p0;

   assign lk_take_p0 = LookupReqValid & lk_hit_p0;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         vld_p1_q  <= 1'b0;
         hit_p1_q  <= 1'b0;
         addr_p1_q <= '0;
         val_p1_q  <= '0;
         key_p1_q  <= '0;
      end else begin
         vld_p1_q  <= LookupReqValid;
         hit_p1_q  <= lk_take_p0;
         addr_p1_q <= lk_take_p0 ? lk_addr_p0 : '0;
         val_p1_q  <= lk_take_p0 ? lk_val_p0 : '0;
         key_p1_q  <= lk_take_p0 ? LookupReqKey : '0;
      end
   end

   // Lookup p2: output registers
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         LookupRespValid <= 1'b0;
         LookupRespHit   <= 1'b0;
         LookupRespAddr  <= '0;
         LookupRespValue <= '0;
         LookupRespKey   <= '0;
      end else begin
         LookupRespValid <= vld_p1_q;
         LookupRespHit   <= hit_p1_q;
         LookupRespAddr  <= addr_p1_q;
         LookupRespValue <= val_p1_q;
         LookupRespKey   <= key_p1_q;
      end
   end

   upd_state_e        state_q, state_d;
   logic              upd_xfer;
   logic              upd_op_q;
   logic [KEY_W-1:0]  upd_key_q;
   logic [VAL_W-1:0]  upd_val_q;
   logic [DEPTH-1:0]  upd_match;
   logic [DEPTH-1:0]  free_vec;
   logic              srch_hit_q;
   logic [ADDR_W-1:0] srch_addr_q;
   logic              free_any_q;
   logic [ADDR_W-1:0] free_idx_q;
   logic              resp_succ_q;
   logic [ADDR_W-1:0] resp_addr_q;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      UpdReqReady = 1'b0;
      upd_xfer    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            UpdReqReady = 1'b1;
            if (UpdReqValid) begin
               upd_xfer = 1'b1;
               state_d  = ST_SEARCH;
            end
         end
         ST_SEARCH: state_d = ST_COMMIT;
         ST_COMMIT: state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         upd_op_q  <= OP_INSERT;
         upd_key_q <= '0;
         upd_val_q <= '0;
      end else if (upd_xfer) begin
         upd_op_q  <= UpdReqOp;
         upd_key_q <= UpdReqKey;
         upd_val_q <= UpdReqValue;
      end
   end

   // Search: existing-key match and first free slot
   cam_match #(.KEY_W(KEY_W), .DEPTH(DEPTH)) u_upd_match (
      .key_i     (upd_key_q),
      .entries_i (key_q),
      .valid_i   (valid_q),
      .match_o   (upd_match)
   );

   assign free_vec = ~valid_q;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         srch_hit_q  <= 1'b0;
         srch_addr_q <= '0;
         free_any_q  <= 1'b0;
         free_idx_q  <= '0;
      end else if (state_q == ST_SEARCH) begin
         srch_hit_q  <= |upd_match;
         srch_addr_q <= lowest_idx(upd_match);
         free_any_q  <= |free_vec;
         free_idx_q  <= lowest_idx(free_vec);
      end
   end

   // Commit: decide the write and its status
   logic              in_commit;
   logic              is_ins;
   logic              do_write;
   logic              do_alloc;
   logic              do_clear;
   logic              commit_succ;
   logic [ADDR_W-1:0] commit_addr;

   always_comb begin
      in_commit   = (state_q == ST_COMMIT);
      is_ins      = (upd_op_q == OP_INSERT);
      do_write    = in_commit & is_ins & (srch_hit_q | free_any_q);
      do_alloc    = in_commit & is_ins & ~srch_hit_q & free_any_q;
      do_clear    = in_commit & ~is_ins & srch_hit_q;
      commit_succ = srch_hit_q | (is_ins & free_any_q);
      commit_addr = '0;
      if (srch_hit_q)                 commit_addr = srch_addr_q;
      else if (is_ins && free_any_q)  commit_addr = free_idx_q;
   end

   always_ff @(posedge Clk) begin
      if (do_write) begin
         key_q[commit_addr] <= upd_key_q;
         val_q[commit_addr] <= upd_val_q;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         valid_q <= '0;
         cnt_q   <= '0;
      end else if (do_alloc) begin
         valid_q[commit_addr] <= 1'b1;
         cnt_q                <= cnt_q + CNT_ONE;
      end else if (do_clear) begin
         valid_q[commit_addr] <= 1'b0;
         cnt_q                <= cnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         resp_succ_q <= 1'b0;
         resp_addr_q <= '0;
      end else if (in_commit) begin
         resp_succ_q <= commit_succ;
         resp_addr_q <= commit_addr;
      end
   end

   // Response: status is only driven during the one-cycle pulse
   assign UpdRespValid   = (state_q == ST_RESP);
   assign UpdRespSuccess = UpdRespValid & resp_succ_q;
   assign UpdRespAddr    = UpdRespValid ? resp_addr_q : '0;
   assign EntryCount     = cnt_q;
   assign Full           = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_param_cam.sv
// Scoreboard bench for param_cam: directed updates and lookups push expected
// responses; a negedge monitor pops and compares them including latency.
module tb_param_cam;

   localparam int KEY_W  = 97;
   localparam int VAL_W  = 14;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam logic [KEY_W-1:0] K_HI = {1'b1, 96'h5};

   logic              Clk = 1'b0;
   logic              Rst_n;
   logic              LookupReqValid;
   logic [KEY_W-1:0]  LookupReqKey;
   logic              LookupRespValid;
   logic              LookupRespHit;
   logic [ADDR_W-1:0] LookupRespAddr;
   logic [KEY_W-1:0]  LookupRespKey;
   logic [VAL_W-1:0]  LookupRespValue;
   logic              UpdReqValid;
   logic              UpdReqReady;
   logic              UpdReqOp;
   logic [KEY_W-1:0]  UpdReqKey;
   logic [VAL_W-1:0]  UpdReqValue;
   logic              UpdRespValid;
   logic              UpdRespSuccess;
   logic [ADDR_W-1:0] UpdRespAddr;
   logic              Full;
   logic [ADDR_W:0]   EntryCount;

   param_cam #(.KEY_W(KEY_W), .VAL_W(VAL_W), .DEPTH(DEPTH)) dut (
      .Clk             (Clk),
      .Rst_n           (Rst_n),
      .LookupReqValid  (LookupReqValid),
      .LookupReqKey    (LookupReqKey),
      .LookupRespValid (LookupRespValid),
      .LookupRespHit   (LookupRespHit),
      .LookupRespAddr  (LookupRespAddr),
      .LookupRespKey   (LookupRespKey),
      .LookupRespValue (LookupRespValue),
      .UpdReqValid     (UpdReqValid),
      .UpdReqReady     (UpdReqReady),
      .UpdReqOp        (UpdReqOp),
      .UpdReqKey       (UpdReqKey),
      .UpdReqValue     (UpdReqValue),
      .UpdRespValid    (UpdRespValid),
      .UpdRespSuccess  (UpdRespSuccess),
      .UpdRespAddr     (UpdRespAddr),
      .Full            (Full),
      .EntryCount      (EntryCount)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic              hit;
      logic [ADDR_W-1:0] addr;
      logic [VAL_W-1:0]  val;
      logic [KEY_W-1:0]  key;
      int                cyc;
   } lk_exp_t;

   typedef struct {
      logic              succ;
      logic [ADDR_W-1:0] addr;
      int                cyc;
   } up_exp_t;

   lk_exp_t lk_q[$];
   up_exp_t up_q[$];
   lk_exp_t lk_e;
   up_exp_t up_e;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge Clk) begin
      if (Rst_n === 1'b1) begin
         if (LookupRespValid) begin
            if (lk_q.size() == 0) begin
               chk("lk_unexpected_resp", 128'(1), 128'(0));
            end else begin
               lk_e = lk_q.pop_front();
               chk("lk_latency", 128'(cyc), 128'(lk_e.cyc));
               chk("lk_resp {hit,addr,val,key}",
                   128'({LookupRespHit, LookupRespAddr, LookupRespValue, LookupRespKey}),
                   128'({lk_e.hit, lk_e.addr, lk_e.val, lk_e.key}));
            end
         end else begin
            chk("lk_idle_zero",
                128'({LookupRespHit, LookupRespAddr, LookupRespValue, LookupRespKey}), 128'(0));
         end
         if (UpdRespValid) begin
            if (up_q.size() == 0) begin
               chk("upd_unexpected_resp", 128'(1), 128'(0));
            end else begin
               up_e = up_q.pop_front();
               chk("upd_latency", 128'(cyc), 128'(up_e.cyc));
               chk("upd_resp {succ,addr}", 128'({UpdRespSuccess, UpdRespAddr}),
                   128'({up_e.succ, up_e.addr}));
            end
         end
      end
   end

   task automatic lk_issue(input logic [KEY_W-1:0] key, input logic hit,
                           input logic [ADDR_W-1:0] addr, input logic [VAL_W-1:0] val);
      lk_exp_t e;
      LookupReqValid = 1'b1;
      LookupReqKey   = key;
      e.hit  = hit;
      e.addr = hit ? addr : '0;
      e.val  = hit ? val : '0;
      e.key  = hit ? key : '0;
      e.cyc  = cyc + 2;
      lk_q.push_back(e);
      @(posedge Clk); #1;
      LookupReqValid = 1'b0;
      LookupReqKey   = '0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((lk_q.size() != 0 || up_q.size() != 0) && n < 20) begin
         @(posedge Clk); #1;
         n++;
      end
      if (lk_q.size() != 0 || up_q.size() != 0) begin
         chk("resp_timeout_pending", 128'(lk_q.size() + up_q.size()), 128'(0));
         lk_q.delete();
         up_q.delete();
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!UpdReqReady && n < 20) begin
         @(posedge Clk); #1;
         n++;
      end
      if (!UpdReqReady) chk("ready_timeout", 128'(UpdReqReady), 128'(1));
   endtask

   task automatic upd_drive(input logic op, input logic [KEY_W-1:0] key, input logic [VAL_W-1:0] val,
                            input logic succ, input logic [ADDR_W-1:0] addr);
      up_exp_t e;
      UpdReqValid = 1'b1;
      UpdReqOp    = op;
      UpdReqKey   = key;
      UpdReqValue = val;
      e.succ = succ;
      e.addr = addr;
      e.cyc  = cyc + 3;
      up_q.push_back(e);
   endtask

   task automatic upd(input logic op, input logic [KEY_W-1:0] key, input logic [VAL_W-1:0] val,
                      input logic succ, input logic [ADDR_W-1:0] addr);
      wait_ready();
      upd_drive(op, key, val, succ, addr);
      @(posedge Clk); #1;
      UpdReqValid = 1'b0;
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Rst_n          = 1'b0;
      LookupReqValid = 1'b0;
      LookupReqKey   = '0;
      UpdReqValid    = 1'b0;
      UpdReqOp       = 1'b0;
      UpdReqKey      = '0;
      UpdReqValue    = '0;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_outputs", 128'({LookupRespValid, LookupRespHit, UpdRespValid, Full, EntryCount}), 128'(0));
      Rst_n = 1'b1;
      chk("rst_ready", 128'(UpdReqReady), 128'(1));
      chk("rst_count", 128'(EntryCount), 128'(0));

      // First insert and lookups
      upd(1'b0, 97'h5, 14'h11, 1'b1, 4'd0);
      chk("cnt_after_first", 128'(EntryCount), 128'(1));
      lk_issue(97'h5, 1'b1, 4'd0, 14'h11);
      lk_issue(97'h6, 1'b0, 4'd0, 14'h0);
      drain();

      // Fill the table
      for (int i = 1; i < DEPTH; i++) begin
         upd(1'b0, 97'h100 + 97'(i), 14'(i), 1'b1, 4'(i));
      end
      chk("full_after_fill", 128'({Full, EntryCount}), 128'({1'b1, 5'd16}));
      upd(1'b0, 97'h999, 14'h1, 1'b0, 4'd0);
      chk("full_after_reject", 128'({Full, EntryCount}), 128'({1'b1, 5'd16}));
      upd(1'b0, 97'h5, 14'h22, 1'b1, 4'd0);
      lk_issue(97'h5, 1'b1, 4'd0, 14'h22);
      lk_issue(97'h10f, 1'b1, 4'd15, 14'd15);
      lk_issue(97'h999, 1'b0, 4'd0, 14'h0);
      drain();

      // Delete index 3, miss delete, reuse slot 3
      upd(1'b1, 97'h103, 14'h0, 1'b1, 4'd3);
      chk("after_delete", 128'({Full, EntryCount}), 128'({1'b0, 5'd15}));
      upd(1'b1, 97'h103, 14'h0, 1'b0, 4'd0);
      chk("after_delete_miss", 128'(EntryCount), 128'(15));
      lk_issue(97'h103, 1'b0, 4'd0, 14'h0);
      drain();
      upd(1'b0, 97'hABC, 14'h33, 1'b1, 4'd3);
      chk("after_reuse", 128'({Full, EntryCount}), 128'({1'b1, 5'd16}));
      lk_issue(97'hABC, 1'b1, 4'd3, 14'h33);
      drain();

      // Back-to-back lookups across a delete commit (commit is the third cycle)
      wait_ready();
      upd_drive(1'b1, 97'h107, 14'h0, 1'b1, 4'd7);
      lk_issue(97'h107, 1'b1, 4'd7, 14'd7);
      UpdReqValid = 1'b0;
      lk_issue(97'h107, 1'b1, 4'd7, 14'd7);
      lk_issue(97'h107, 1'b1, 4'd7, 14'd7);
      lk_issue(97'h107, 1'b0, 4'd0, 14'h0);
      lk_issue(97'h107, 1'b0, 4'd0, 14'h0);
      drain();
      chk("cnt_after_b2b", 128'(EntryCount), 128'(15));

      // Full-width key compare: differs from key 5 only in the MSB
      upd(1'b0, K_HI, 14'h44, 1'b1, 4'd7);
      lk_issue(K_HI, 1'b1, 4'd7, 14'h44);
      lk_issue(97'h5, 1'b1, 4'd0, 14'h22);
      drain();

      // Reset while the update engine is in SEARCH
      wait_ready();
      UpdReqValid = 1'b1;
      UpdReqOp    = 1'b1;
      UpdReqKey   = 97'h5;
      @(posedge Clk); #1;
      UpdReqValid = 1'b0;
      Rst_n = 1'b0;
      #1;
      chk("midrst_outputs", 128'({UpdRespValid, LookupRespValid, Full, EntryCount}), 128'(0));
      repeat (2) @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      repeat (5) @(posedge Clk);
      #1;
      chk("midrst_count", 128'({Full, EntryCount}), 128'(0));
      chk("midrst_ready", 128'(UpdReqReady), 128'(1));
      lk_issue(97'h5, 1'b0, 4'd0, 14'h0);
      lk_issue(K_HI, 1'b0, 4'd0, 14'h0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
